// File: rtl/memory_master.sv
// memory_master: bus initiator for the 16-bit word memory. Sequences single and burst
// reads/writes, and drives the shared data bus only during write beats.
module memory_master #(
    parameter int unsigned address_size = 16,
    parameter int unsigned burst_width  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    req_write,
    input  logic [address_size-1:0] req_addr,
    input  logic [burst_width-1:0]  req_len,
    input  logic [15:0]             wr_data,
    output logic                    wr_ready,
    output logic [15:0]             rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic [address_size-1:0] mem_address,
    output logic                    mem_read_write,
    output logic                    mem_enable,
    inout  logic [15:0]             mem_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, READ_TAIL} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [address_size-1:0] addr_q;
    logic [burst_width-1:0]  len_q;
    logic [burst_width-1:0]  beat_q;
    logic                    last_beat;

    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req) state_next = req_write ? WRITE : READ;
            WRITE:     if (last_beat) state_next = IDLE;
            READ:      if (last_beat) state_next = READ_TAIL;
            READ_TAIL: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_enable     = (state != IDLE);
        mem_read_write = (state != WRITE);
        wr_ready       = (state == WRITE);
        busy           = (state != IDLE);
    end

    assign mem_address = addr_q;
    assign mem_data    = wr_ready ? wr_data : 'z;

    // Read words arrive one cycle after their beat; beat 0 has no word yet, and
    // READ_TAIL holds the last address so the final word stays on the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= req_addr;
                        len_q  <= req_len;
                        beat_q <= '0;
                    end
                end
                WRITE: begin
                    if (last_beat) begin
                        done <= 1'b1;
                    end else begin
                        addr_q <= addr_q + address_size'(1);
                        beat_q <= beat_q + burst_width'(1);
                    end
                end
                READ: begin
                    if (beat_q != '0) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem_data;
                    end
                    if (!last_beat) begin
                        addr_q <= addr_q + address_size'(1);
                        beat_q <= beat_q + burst_width'(1);
                    end
                end
                READ_TAIL: begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem_data;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_master.sv
// tb_memory_master: drives memory_master against a word-memory device model and checks
// bus sequencing, read return and completion against a reference memory image.
module tb_memory_master;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req       = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [3:0]  req_len   = '0;
    logic [15:0] wr_data   = '0;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic        mem_read_write;
    logic        mem_enable;
    wire  [15:0] mem_data;

    int errors = 0;
    int checks = 0;

    logic [15:0] dev_mem [0:65535] = '{default: '0};
    logic [15:0] ref_mem [0:65535] = '{default: '0};
    logic [15:0] dev_out = '0;
    logic        dev_drv = 1'b0;
    logic [15:0] wdata [0:15];
    logic [15:0] last_rd = '0;
    logic [15:0] last_wbase = '0;

    memory_master #(.address_size(16), .burst_width(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_enable     (mem_enable),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;

    // Memory device: stores on write edges, registers a read word and drives it next cycle.
    always @(posedge clk) begin
        if (mem_enable && !mem_read_write) dev_mem[mem_address] <= mem_data;
        if (mem_enable && mem_read_write) dev_out <= dev_mem[mem_address];
        dev_drv <= mem_enable && mem_read_write;
    end
    assign mem_data = (dev_drv && mem_enable && mem_read_write) ? dev_out : 'z;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        #1;
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_done", done, 1'b0);
        chk1("idle_en", mem_enable, 1'b0);
        chk1("idle_rd_valid", rd_valid, 1'b0);
        chk1("idle_wr_ready", wr_ready, 1'b0);
        chk16("idle_rd_hold", rd_data, last_rd);
    endtask

    // Issues a burst from the current negedge and checks every cycle up to the done cycle.
    // Returns in the done cycle so a following call exercises back-to-back acceptance.
    task automatic run_burst(input logic wr, input logic [15:0] base, input int unsigned len,
                             input bit pulse);
        int unsigned n;
        int unsigned last_c;
        int unsigned rv_cnt;
        int unsigned done_cnt;
        int unsigned busy_cnt;
        logic [15:0] exp_word;
        n        = len + 1;
        last_c   = wr ? n : n + 1;
        rv_cnt   = 0;
        done_cnt = 0;
        busy_cnt = 0;
        req       = 1'b1;
        req_write = wr;
        req_addr  = base;
        req_len   = 4'(len);
        @(negedge clk);
        req = 1'b0;
        for (int unsigned c = 0; c <= last_c; c++) begin
            if (pulse && c == 3) begin
                req       = 1'b1;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom);
                req_len   = 4'($urandom);
            end
            if (c == 4) req = 1'b0;
            if (wr && c < n) wr_data = wdata[c];
            #1;
            if (c < n) begin
                chk16("beat_addr", mem_address, base + 16'(c));
                chk1("beat_en", mem_enable, 1'b1);
                chk1("beat_rw", mem_read_write, !wr);
                chk1("beat_wr_ready", wr_ready, wr);
                if (wr) chk16("wr_bus", mem_data, wdata[c]);
            end else if (!wr && c == n) begin
                chk16("tail_addr", mem_address, base + 16'(len));
                chk1("tail_en", mem_enable, 1'b1);
                chk1("tail_rw", mem_read_write, 1'b1);
                chk1("tail_wr_ready", wr_ready, 1'b0);
            end
            chk1("busy", busy, c < last_c);
            chk1("done", done, c == last_c);
            chk1("rd_valid", rd_valid, !wr && c >= 2);
            if (rd_valid) rv_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (!wr && c >= 2) begin
                exp_word = ref_mem[base + 16'(c - 2)];
                chk16("rd_data", rd_data, exp_word);
                last_rd = exp_word;
            end
            if (c < last_c) @(negedge clk);
        end
        chki("rv_count", rv_cnt, wr ? 0 : n);
        chki("done_count", done_cnt, 1);
        chki("busy_cycles", busy_cnt, last_c);
        if (wr) begin
            for (int unsigned i = 0; i < n; i++) ref_mem[base + 16'(i)] = wdata[i];
            last_wbase = base;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_en", mem_enable, 1'b0);
        chk1("rst_rw", mem_read_write, 1'b1);
        chk16("rst_addr", mem_address, 16'h0000);
        chk16("rst_rd_data", rd_data, 16'h0000);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_wr_ready", wr_ready, 1'b0);
        reset = 1'b1;
        idle_cycle();

        // Single write then single read
        wdata[0] = 16'hBEEF;
        run_burst(1'b1, 16'h0010, 0, 1'b0);
        idle_cycle();
        run_burst(1'b0, 16'h0010, 0, 1'b0);
        chk16("single_rd", last_rd, 16'hBEEF);
        idle_cycle();

        // Four-word burst
        wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333; wdata[3] = 16'h4444;
        run_burst(1'b1, 16'h0100, 3, 1'b0);
        idle_cycle();
        run_burst(1'b0, 16'h0100, 3, 1'b0);
        idle_cycle();

        // Address wrap
        wdata[0] = 16'hC0DE; wdata[1] = 16'hCAFE; wdata[2] = 16'hD00D; wdata[3] = 16'hF00D;
        run_burst(1'b1, 16'hFFFE, 3, 1'b0);
        chk16("wrap_mem_fffe", dev_mem[16'hFFFE], 16'hC0DE);
        chk16("wrap_mem_ffff", dev_mem[16'hFFFF], 16'hCAFE);
        chk16("wrap_mem_0000", dev_mem[16'h0000], 16'hD00D);
        chk16("wrap_mem_0001", dev_mem[16'h0001], 16'hF00D);
        idle_cycle();
        run_burst(1'b0, 16'hFFFE, 3, 1'b0);
        idle_cycle();

        // Long read with a stray req in the middle
        for (int i = 0; i < 16; i++) wdata[i] = 16'($urandom);
        run_burst(1'b1, 16'h0100, 15, 1'b0);
        idle_cycle();
        run_burst(1'b0, 16'h0100, 15, 1'b1);
        idle_cycle();

        // Reset in cycle 2 of a four-word write
        wdata[0] = 16'hA0A0; wdata[1] = 16'hA1A1; wdata[2] = 16'hA2A2; wdata[3] = 16'hA3A3;
        run_burst(1'b1, 16'h0200, 3, 1'b0);
        idle_cycle();
        req = 1'b1; req_write = 1'b1; req_addr = 16'h0200; req_len = 4'd3;
        @(negedge clk);
        req = 1'b0; wr_data = 16'h5A01;
        @(negedge clk);
        wr_data = 16'h5A02;
        @(negedge clk);
        wr_data = 16'h5A03;
        reset = 1'b0;
        #1;
        chk1("abort_en", mem_enable, 1'b0);
        chk1("abort_rw", mem_read_write, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_wr_ready", wr_ready, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk16("abort_addr", mem_address, 16'h0000);
        @(negedge clk);
        #1;
        chk1("abort_done_late", done, 1'b0);
        chk1("abort_rd_valid", rd_valid, 1'b0);
        reset = 1'b1;
        ref_mem[16'h0200] = 16'h5A01;
        ref_mem[16'h0201] = 16'h5A02;
        last_rd = 16'h0000;
        chk16("abort_kept_w2", dev_mem[16'h0202], 16'hA2A2);
        chk16("abort_kept_w3", dev_mem[16'h0203], 16'hA3A3);
        idle_cycle();
        run_burst(1'b0, 16'h0200, 3, 1'b0);
        idle_cycle();

        // Back-to-back: each req issued in the previous burst's done cycle
        wdata[0] = 16'h7001; wdata[1] = 16'h7002; wdata[2] = 16'h7003;
        run_burst(1'b1, 16'h0300, 2, 1'b0);
        run_burst(1'b0, 16'h0300, 2, 1'b0);
        wdata[0] = 16'h8001; wdata[1] = 16'h8002;
        run_burst(1'b1, 16'h0400, 1, 1'b0);
        run_burst(1'b0, 16'h0400, 1, 1'b0);
        idle_cycle();

        // Randomized bursts, reads biased toward recently written regions
        for (int k = 0; k < 24; k++) begin
            logic        rw;
            logic [15:0] b;
            int unsigned l;
            rw = 1'($urandom_range(0, 1));
            b  = 16'($urandom);
            l  = $urandom_range(0, 15);
            if (!rw && $urandom_range(0, 3) != 0) b = last_wbase;
            for (int i = 0; i < 16; i++) wdata[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 0) idle_cycle();
            run_burst(rw, b, l, 1'b0);
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_master.md
Name: memory_master

Overview:
Bus initiator for the 16-bit word memory.
- Accepts single or burst read/write requests from a client (CPU datapath, loader).
- Sequences the memory's address, read_write, enable and bidirectional data lines.
- Drives the shared data bus only during write beats and returns read words with a valid strobe.
- Sits between the control unit and the memory; it is the only master on the memory data bus.

Parameters:
address_size, 16, width of memory address and req_addr
burst_width, 4, width of req_len; a burst is req_len+1 words (1..2^burst_width)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 = reset
req  input  1  request strobe, sampled only in IDLE
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  address_size  first word address
req_len  input  burst_width  number of words minus one
wr_data  input  16  current write word; must be valid in every cycle wr_ready=1
wr_ready  output  1  high during each write beat; wr_data consumed at end of that cycle
rd_data  output  16  registered read word
rd_valid  output  1  one-cycle strobe per read word
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on return to IDLE after a completed burst
mem_address  output  address_size  to memory address
mem_read_write  output  1  to memory read_write (1 = read, 0 = write)
mem_enable  output  1  to memory enable
mem_data  inout  16  shared data bus; driven with wr_data only in WRITE, else high-Z

Behaviour:
- Reset (async, reset=0): state=IDLE. mem_enable=0, mem_read_write=1, mem_address=0, mem_data=Z. rd_data=0; rd_valid, done, busy, wr_ready=0. Internal counters=0.
- States: IDLE, WRITE, READ, READ_TAIL.
- IDLE: mem_enable=0, bus Z.
  - req=1 at a rising edge latches req_write, req_addr, req_len.
  - Next state is WRITE or READ; call that first cycle cycle 0.
  - req is ignored when state != IDLE; no queuing.
- Beat addressing: beat i (0..N-1, N=req_len+1) uses mem_address = base+i, modulo 2^address_size; 0xFFFF wraps to 0x0000.
- WRITE, beat i in cycle i:
  - mem_enable=1, mem_read_write=0, mem_data=wr_data, wr_ready=1.
  - Memory stores the word at that rising edge.
  - After beat N-1: go to IDLE in cycle N with done=1. One word per cycle, no stalls.
- READ, beat i in cycle i:
  - mem_enable=1, mem_read_write=1, bus Z.
  - Memory loads its output register at the end of cycle i and drives the bus during cycle i+1 while enable stays high.
  - Master samples mem_data at the end of cycles 1..N.
- READ_TAIL (cycle N):
  - mem_enable=1, mem_read_write=1, mem_address holds base+N-1, so the memory's re-read is harmless.
  - Exists only to keep the last word on the bus.
- Read return: word j appears on rd_data with rd_valid=1 in cycle j+2.
- Read completion: cycle N+1 is IDLE, with done=1 and the last rd_valid.
- Read latency: 2 cycles from a beat's address to rd_valid. A burst occupies N+1 busy cycles; a write burst occupies N.
- rd_data holds its last value when rd_valid=0.
- Bus contention: the master never drives mem_data while mem_read_write=1. The memory never drives while mem_read_write=0. The transition READ→IDLE→WRITE always passes through at least one cycle with enable=0.
- Back-to-back: a new req may be accepted in the done cycle (IDLE). Its cycle 0 immediately follows.
- Reset mid-burst: immediate abort. Outputs go to reset values asynchronously and the bus is released. No done and no further rd_valid. Words already written stay written.
- done and rd_valid in the same cycle occur only on the last read word.

Test Plan:
- Single write 0x0010←0xBEEF, then single read 0x0010 against the memory model → wr_ready 1 cycle, done in cycle 1. Read: rd_valid only in cycle 2 with rd_data=0xBEEF, done in cycle 2.
- Burst write len=3 at 0x0100 with data 0x1111,0x2222,0x3333,0x4444, then burst read → rd_valid in cycles 2..5 carrying the four words in order. busy is 4 cycles for the write and 5 for the read.
- Wrap: write len=3 at 0xFFFE → memory locations 0xFFFE, 0xFFFF, 0x0000, 0x0001 hold the data; read back matches.
- req pulsed during a busy read burst (len=15) → ignored. Exactly 16 rd_valid pulses, one done.
- Reset asserted in cycle 2 of a 4-word write → mem_enable=0 and mem_data=Z immediately, no done. Words 0..1 written, words 2..3 unchanged.
- New req in the done cycle → accepted. Cycle 0 of the second burst is the next cycle; no bus contention, no X on mem_data.
